demux_1_to_8_buffer: RTL and testbench
======================================

# demux_1_to_8_buffer

Registered 1-to-8 distributor: accepts 64-bit words on a valid/ready input and steers each into one of eight holding slots, addressed explicitly by a 3-bit select or implicitly by an internal auto-increment pointer. It sits ahead of the 8-to-1 selection stage in the factorial datapath, filling that stage's eight 64-bit operands. Each slot carries an occupancy flag that the consumer clears per slot. Writes to an occupied slot are back-pressured, never overwritten.

## Interface
- DATA_WIDTH, 64, width of every data word and slot.
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all occupancy flags and wr_ptr; data registers retained.
- s_valid  in  1  input word valid.
- s_ready  out  1  block can accept the word currently addressed.
- s_auto  in  1  1: target = wr_ptr; 0: target = s_sel.
- s_sel  in  3  explicit target slot (0..7), used when s_auto = 0.
- s_data  in  DATA_WIDTH  input word.
- slot_clr  in  8  per-slot consumer acknowledge; bit i clears slot_valid[i].
- a_out … h_out  out  DATA_WIDTH each  slot 0 … slot 7 registered contents.
- slot_valid  out  8  per-slot occupancy flag.
- wr_ptr  out  3  auto-mode write pointer.
- all_full  out  1  &slot_valid.

## Operation
- Target slot T = s_auto ? wr_ptr : s_sel.
- s_ready = ~flush & (~slot_valid[T] | slot_clr[T]).
  - Combinational in flush, s_auto, s_sel, wr_ptr, slot_valid and slot_clr.
  - Independent of s_valid.
- Transfer: s_valid & s_ready at a rising clk edge. On transfer:
  - slot T data <= s_data.
  - slot_valid[T] <= 1.
  - If s_auto = 1: wr_ptr <= wr_ptr + 1, mod 8, wrapping 7 -> 0.
- Explicit-select transfers never move wr_ptr.
- slot_clr[i] = 1 at an edge: slot_valid[i] <= 0, unless slot i is the transfer target that same edge.
  - On a simultaneous write and clear of the same slot, the write wins: slot_valid stays 1 and the new data is latched.
  - Clears of non-target slots apply in the same edge as a transfer.
- Clearing a slot does not alter its data; x_out holds the last written value.
- s_valid = 1 with s_ready = 0: no state change.
  - The source must hold s_data, s_sel and s_auto stable until the transfer.
- flush = 1 at an edge:
  - slot_valid <= 0 and wr_ptr <= 0.
  - Any transfer and slot_clr in that cycle are ignored (s_ready is 0).
  - Data registers are unchanged.
- Priority, highest first: reset > flush > transfer > slot_clr.
- all_full = 1 iff all eight flags are set.
  - In auto mode with all_full = 1, s_ready = 0 unless slot_clr[wr_ptr] = 1.

## Timing
- Reset values:
  - a_out..h_out = 0.
  - slot_valid = 8'h00.
  - wr_ptr = 0.
  - all_full = 0.
  - s_ready = 1, provided flush = 0.
- Reset asserted mid-stream: state returns to the reset values at that edge; any handshake in that cycle is discarded.
- Write latency is 1 cycle. Data and slot_valid update at the transfer edge and are visible on outputs immediately after it.
- Throughput is one word per cycle while targets are free.
- Clear latency is 1 cycle. slot_valid drops at the edge where slot_clr is sampled.
- Clear-to-ready is same-cycle: slot_clr[T] = 1 raises s_ready combinationally in that cycle.
- wr_ptr changes only at auto-mode transfer edges, flush or reset.

## Test plan
- Reset, then 8 auto writes with s_data = 1..8 on consecutive cycles. Expected:
  - a_out = 1 … h_out = 8.
  - slot_valid = 8'hFF, all_full = 1.
  - wr_ptr wraps to 0; s_ready = 0 on the 9th cycle.
- Full buffer, 9th auto write with s_data = 9 and slot_clr = 8'h01 in the same cycle. Expected:
  - s_ready = 1, a_out = 9, slot_valid[0] stays 1, wr_ptr = 1.
- Explicit writes: s_sel = 5, s_data = 64'hDEAD, then s_sel = 5 again without a clear. Expected:
  - f_out = 64'hDEAD, slot_valid = 8'h20.
  - The second write stalls with s_ready = 0 and f_out unchanged.
  - wr_ptr stays 0.
- Write slot 2 while clearing slot 6 in the same cycle (slot 6 previously valid). Expected:
  - slot_valid[2] = 1, slot_valid[6] = 0, g_out data retained.
- flush after 3 auto writes, with s_valid = 1 held during the flush cycle. Expected:
  - slot_valid = 0, wr_ptr = 0, no write occurs, a_out..c_out unchanged.
- Reset asserted after 4 auto writes. Expected:
  - All outputs 0 and wr_ptr = 0.
  - The next auto write lands in slot 0.

Source files
------------

// File: rtl/demux_1_to_8_buffer.sv
// Registered 1-to-8 distributor: steers valid/ready input words into eight holding slots,
// each with a consumer-cleared occupancy flag. Occupied slots back-pressure, never overwrite.
module demux_1_to_8_buffer #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_auto,
  input  logic [2:0]            s_sel,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [7:0]            slot_clr,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic [DATA_WIDTH-1:0] c_out,
  output logic [DATA_WIDTH-1:0] d_out,
  output logic [DATA_WIDTH-1:0] e_out,
  output logic [DATA_WIDTH-1:0] f_out,
  output logic [DATA_WIDTH-1:0] g_out,
  output logic [DATA_WIDTH-1:0] h_out,
  output logic [7:0]            slot_valid,
  output logic [2:0]            wr_ptr,
  output logic                  all_full
);

  logic [DATA_WIDTH-1:0] data_q [8];
  logic [7:0]            valid_q, valid_d;
  logic [2:0]            ptr_q, ptr_d;
  logic [2:0]            tgt;
  logic                  xfer;

  assign tgt     = s_auto ? ptr_q : s_sel;
  // A same-cycle clear of the target frees it for this cycle's write.
  assign s_ready = ~flush & (~valid_q[tgt] | slot_clr[tgt]);
  assign xfer    = s_valid & s_ready;

  always_comb begin
    valid_d = valid_q & ~slot_clr;
    ptr_d   = ptr_q;
    if (xfer) begin
      valid_d[tgt] = 1'b1;
      if (s_auto) ptr_d = ptr_q + 3'd1;
    end
    if (flush) begin
      valid_d = 8'h00;
      ptr_d   = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 8'h00;
      ptr_q   <= 3'd0;
      for (int i = 0; i < 8; i++) data_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      if (xfer) data_q[tgt] <= s_data;
    end
  end

  assign a_out      = data_q[0];
  assign b_out      = data_q[1];
  assign c_out      = data_q[2];
  assign d_out      = data_q[3];
  assign e_out      = data_q[4];
  assign f_out      = data_q[5];
  assign g_out      = data_q[6];
  assign h_out      = data_q[7];
  assign slot_valid = valid_q;
  assign wr_ptr     = ptr_q;
  assign all_full   = &valid_q;

endmodule

// File: tb/tb_demux_1_to_8_buffer.sv
// Scoreboard bench: stimulus pushes hand-derived expected state per cycle; a negedge monitor
// pops and compares against the DUT outputs.
module tb_demux_1_to_8_buffer;

  logic        clk = 1'b0;
  logic        reset, flush, s_valid, s_ready, s_auto;
  logic [2:0]  s_sel, wr_ptr;
  logic [63:0] s_data;
  logic [7:0]  slot_clr, slot_valid;
  logic        all_full;
  logic [63:0] a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out;
  logic [63:0] outs [8];

  always #5 clk = ~clk;

  demux_1_to_8_buffer #(.DATA_WIDTH(64)) dut (
    .clk(clk), .reset(reset), .flush(flush), .s_valid(s_valid), .s_ready(s_ready),
    .s_auto(s_auto), .s_sel(s_sel), .s_data(s_data), .slot_clr(slot_clr),
    .a_out(a_out), .b_out(b_out), .c_out(c_out), .d_out(d_out),
    .e_out(e_out), .f_out(f_out), .g_out(g_out), .h_out(h_out),
    .slot_valid(slot_valid), .wr_ptr(wr_ptr), .all_full(all_full)
  );

  assign outs[0] = a_out;
  assign outs[1] = b_out;
  assign outs[2] = c_out;
  assign outs[3] = d_out;
  assign outs[4] = e_out;
  assign outs[5] = f_out;
  assign outs[6] = g_out;
  assign outs[7] = h_out;

  typedef struct {
    string           name;
    int              cyc;
    logic [7:0][63:0] data;
    logic [7:0]      valid;
    logic [2:0]      ptr;
    logic            full;
    logic            ready;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  logic [7:0][63:0] exp_data;
  logic [7:0]       exp_valid;
  logic [2:0]       exp_ptr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: compares every expectation scheduled for the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        chk({e.name, " stale"}, 64'(cyc), 64'(e.cyc));
      end else begin
        for (int i = 0; i < 8; i++) chk($sformatf("%s data[%0d]", e.name, i), outs[i], e.data[i]);
        chk({e.name, " slot_valid"}, 64'(slot_valid), 64'(e.valid));
        chk({e.name, " wr_ptr"}, 64'(wr_ptr), 64'(e.ptr));
        chk({e.name, " all_full"}, 64'(all_full), 64'(e.full));
        chk({e.name, " s_ready"}, 64'(s_ready), 64'(e.ready));
      end
    end
  end

  task automatic drive(input logic v, input logic a, input logic [2:0] sel,
                       input logic [63:0] d, input logic [7:0] clr,
                       input logic fl, input logic rst);
    @(posedge clk);
    #1;
    s_valid = v; s_auto = a; s_sel = sel; s_data = d;
    slot_clr = clr; flush = fl; reset = rst;
  endtask

  // Expected state as seen during the current cycle (i.e. after the previous edge).
  task automatic expect_now(input string name, input logic rdy);
    exp_t e;
    e.name = name; e.cyc = cyc; e.data = exp_data; e.valid = exp_valid;
    e.ptr = exp_ptr; e.full = (exp_valid == 8'hFF); e.ready = rdy;
    sb.push_back(e);
  endtask

  task automatic clear_model();
    exp_data = '0; exp_valid = 8'h00; exp_ptr = 3'd0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; s_valid = 1'b0; s_auto = 1'b1; s_sel = 3'd0;
    s_data = '0; slot_clr = 8'h00;
    clear_model();
    drive(0, 1, 0, 0, 8'h00, 0, 1);

    // Reset state
    drive(0, 1, 0, 0, 8'h00, 0, 0);
    expect_now("reset", 1'b1);

    // Eight auto writes 1..8
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 0, 64'(i + 1), 8'h00, 0, 0);
      expect_now($sformatf("auto%0d", i), 1'b1);
      exp_data[i] = 64'(i + 1); exp_valid[i] = 1'b1; exp_ptr = 3'(i + 1);
    end
    // Full, ptr wrapped: 9th write stalls
    drive(1, 1, 0, 64'd9, 8'h00, 0, 0);
    expect_now("full_stall", 1'b0);
    // Clear of slot 0 in same cycle lets the write through; write wins
    drive(1, 1, 0, 64'd9, 8'h01, 0, 0);
    expect_now("clr_and_write", 1'b1);
    exp_data[0] = 64'd9; exp_ptr = 3'd1;
    drive(0, 1, 0, 0, 8'h00, 0, 0);
    expect_now("after_clr_write", 1'b0);

    // Flush, then explicit writes to slot 5
    drive(0, 1, 0, 0, 8'h00, 1, 0);
    expect_now("flush1", 1'b0);
    exp_valid = 8'h00; exp_ptr = 3'd0;
    drive(1, 0, 5, 64'hDEAD, 8'h00, 0, 0);
    expect_now("sel5_write", 1'b1);
    exp_data[5] = 64'hDEAD; exp_valid = 8'h20;
    drive(1, 0, 5, 64'hBEEF, 8'h00, 0, 0);
    expect_now("sel5_stall_a", 1'b0);
    drive(1, 0, 5, 64'hBEEF, 8'h00, 0, 0);
    expect_now("sel5_stall_b", 1'b0);

    // Fill slot 6, then write slot 2 while clearing slot 6
    drive(1, 0, 6, 64'h66, 8'h00, 0, 0);
    expect_now("sel6_write", 1'b1);
    exp_data[6] = 64'h66; exp_valid = 8'h60;
    drive(1, 0, 2, 64'h22, 8'h40, 0, 0);
    expect_now("sel2_clr6", 1'b1);
    exp_data[2] = 64'h22; exp_valid = 8'h24;
    drive(0, 0, 6, 0, 8'h00, 0, 0);
    expect_now("slot6_free", 1'b1);
    // Clear-to-ready without a write
    drive(0, 0, 5, 0, 8'h20, 0, 0);
    expect_now("clr5_ready", 1'b1);
    exp_valid = 8'h04;

    // Flush with s_valid held after 3 auto writes
    drive(0, 1, 0, 0, 8'h00, 1, 0);
    expect_now("flush2", 1'b0);
    exp_valid = 8'h00;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 64'hA1 + 64'(i), 8'h00, 0, 0);
      expect_now($sformatf("pre_flush%0d", i), 1'b1);
      exp_data[i] = 64'hA1 + 64'(i); exp_valid[i] = 1'b1; exp_ptr = 3'(i + 1);
    end
    drive(1, 1, 0, 64'hFF, 8'h00, 1, 0);
    expect_now("flush_with_valid", 1'b0);
    exp_valid = 8'h00; exp_ptr = 3'd0;
    drive(0, 1, 0, 0, 8'h00, 0, 0);
    expect_now("post_flush", 1'b1);

    // Reset mid-stream after 4 auto writes
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 64'hB1 + 64'(i), 8'h00, 0, 0);
      expect_now($sformatf("pre_reset%0d", i), 1'b1);
      exp_data[i] = 64'hB1 + 64'(i); exp_valid[i] = 1'b1; exp_ptr = 3'(i + 1);
    end
    drive(1, 1, 0, 64'hCC, 8'h00, 0, 1);
    expect_now("reset_cycle", 1'b1);
    clear_model();
    drive(1, 1, 0, 64'hD1, 8'h00, 0, 0);
    expect_now("post_reset", 1'b1);
    exp_data[0] = 64'hD1; exp_valid = 8'h01; exp_ptr = 3'd1;
    drive(0, 1, 0, 0, 8'h00, 0, 0);
    expect_now("first_after_reset", 1'b1);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
